// File: rtl/axis_nco_sweeper_pkg.sv
// axis_nco_sweeper shared types and helpers.
// NCO step sweep sequencer package.
package axis_nco_sweeper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EMIT,
    DWELL,
    DONE
  } sweep_state_e;

  typedef enum logic [1:0] {
    M_SINGLE  = 2'b00,
    M_SAW     = 2'b01,
    M_TRI     = 2'b10,
    M_SINGLE2 = 2'b11
  } sweep_mode_e;

  function automatic int step_w(input int frac_w, input int int_w);
    return frac_w + int_w;
  endfunction

  localparam int STEP_W_DEF = step_w(24, 8);

endpackage

// File: rtl/axis_nco_sweeper_if.sv
// axis_nco_sweeper AXI-stream step channel.
// Master drives tdata/tvalid, slave drives tready.
interface axis_nco_sweeper_if
  import axis_nco_sweeper_pkg::*;
#(
  parameter int W = STEP_W_DEF
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/axis_nco_sweeper_step_calc.sv
// axis_nco_sweeper next-step calculator.
// Clamped forward step, turn-around step, endpoint flag.
module axis_nco_sweeper_step_calc #(
  parameter int W = 32
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] delta,
  input  logic [W-1:0] stop,
  input  logic [W-1:0] alt,
  input  logic         dir,
  output logic [W-1:0] next,
  output logic [W-1:0] turn,
  output logic         at_end
);

  // one extra bit catches carry (up) or borrow (down)
  function automatic logic [W-1:0] step(
    input logic [W-1:0] c,
    input logic [W-1:0] d,
    input logic [W-1:0] s,
    input logic         up
  );
    logic [W:0] r;
    if (up) begin
      r = {1'b0, c} + {1'b0, d};
      step = (r > {1'b0, s}) ? s : r[W-1:0];
    end else begin
      r = {1'b0, c} - {1'b0, d};
      step = (r[W] || (r[W-1:0] < s)) ? s : r[W-1:0];
    end
  endfunction

  assign next   = step(cur, delta, stop, dir);
  assign turn   = step(cur, delta, alt, !dir);
  assign at_end = (cur == stop) || (delta == '0);

endmodule

// File: rtl/axis_nco_sweeper.sv
// axis_nco_sweeper top: sweep FSM and datapath.
// Ramps NCO steps start->stop with dwell per step.
module axis_nco_sweeper
  import axis_nco_sweeper_pkg::*;
#(
  parameter int ACC_FRAC_WIDTH = 24,
  parameter int ACC_INT_WIDTH  = 8,
  parameter int DWELL_W        = 16,
  parameter int CNT_W          = 16,
  localparam int STEP_W =
    step_w(ACC_FRAC_WIDTH, ACC_INT_WIDTH)
) (
  input  logic               aclk,
  input  logic               arst_n,
  input  logic [STEP_W-1:0]  cfg_start_step,
  input  logic [STEP_W-1:0]  cfg_stop_step,
  input  logic [STEP_W-1:0]  cfg_delta,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  axis_nco_sweeper_if.master m_axis_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_count
);

  sweep_state_e state, state_nx;
  sweep_mode_e  mode_r;

  logic [STEP_W-1:0]  start_r, stop_r, delta_r;
  logic [STEP_W-1:0]  cur, tgt, alt, nxt, turn;
  logic [DWELL_W-1:0] dwell_r, dwell_cnt;
  logic dir, leg, abort_pend, at_end;
  logic hs, kill, single, adv, bump;

  assign single = !(mode_r == M_SAW ||
                    mode_r == M_TRI);
  assign tgt  = leg ? start_r : stop_r;
  assign alt  = leg ? stop_r : start_r;
  assign hs   = (state == EMIT) &&
                m_axis_data.tready;
  assign kill = abort || abort_pend;
  assign bump = (state == DONE) ||
                (hs && at_end &&
                 ((mode_r == M_SAW) ||
                  (mode_r == M_TRI && leg)));

  assign m_axis_data.tvalid = (state == EMIT);
  assign m_axis_data.tdata  = cur;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  axis_nco_sweeper_step_calc #(
    .W (STEP_W)
  ) u_calc (
    .cur    (cur),
    .delta  (delta_r),
    .stop   (tgt),
    .alt    (alt),
    .dir    (dir),
    .next   (nxt),
    .turn   (turn),
    .at_end (at_end)
  );

  // state register
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  // next state and step-advance strobe
  always_comb begin
    state_nx = state;
    adv      = 1'b0;
    unique case (state)
      IDLE:
        if (start && !abort) state_nx = LOAD;
      LOAD:
        state_nx = abort ? IDLE : EMIT;
      EMIT:
        if (hs) begin
          if (kill)
            state_nx = IDLE;
          else if (at_end && single)
            state_nx = DONE;
          else if (dwell_r != '0)
            state_nx = DWELL;
          else
            adv = 1'b1;
        end
      DWELL:
        if (abort) begin
          state_nx = IDLE;
        end else if (dwell_cnt == '0) begin
          state_nx = EMIT;
          adv      = 1'b1;
        end
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  // shadow cfg, current step, dwell and sweep counters
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      start_r     <= '0;
      stop_r      <= '0;
      delta_r     <= '0;
      dwell_r     <= '0;
      mode_r      <= M_SINGLE;
      cur         <= '0;
      dir         <= 1'b0;
      leg         <= 1'b0;
      dwell_cnt   <= '0;
      abort_pend  <= 1'b0;
      sweep_count <= '0;
    end else begin
      if (state == IDLE && start && !abort) begin
        start_r     <= cfg_start_step;
        stop_r      <= cfg_stop_step;
        delta_r     <= cfg_delta;
        dwell_r     <= cfg_dwell;
        mode_r      <= sweep_mode_e'(cfg_mode);
        sweep_count <= '0;
      end else if (bump && sweep_count != '1) begin
        sweep_count <= sweep_count + 1'b1;
      end
      if (state == LOAD) begin
        cur <= start_r;
        dir <= (stop_r >= start_r);
        leg <= 1'b0;
      end
      if (hs)
        dwell_cnt <= dwell_r - 1'b1;
      else if (state == DWELL)
        dwell_cnt <= dwell_cnt - 1'b1;
      if (adv) begin
        if (!at_end) begin
          cur <= nxt;
        end else if (mode_r == M_TRI) begin
          cur <= turn;
          dir <= !dir;
          leg <= !leg;
        end else begin
          cur <= start_r;
        end
      end
      abort_pend <= (state == EMIT) && !hs && kill;
    end
  end

endmodule

// File: tb/tb_axis_nco_sweeper.sv
// tb_axis_nco_sweeper: random + directed sweeps
// checked against a list-based sweep model.
module tb_axis_nco_sweeper;

  logic        aclk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] cfg_start_step, cfg_stop_step, cfg_delta;
  logic [15:0] cfg_dwell;
  logic [1:0]  cfg_mode;
  logic        start, abort;
  logic        busy, done;
  logic [15:0] sweep_count;

  axis_nco_sweeper_if #(.W(32)) bus ();

  axis_nco_sweeper dut (
    .aclk           (aclk),
    .arst_n         (arst_n),
    .cfg_start_step (cfg_start_step),
    .cfg_stop_step  (cfg_stop_step),
    .cfg_delta      (cfg_delta),
    .cfg_dwell      (cfg_dwell),
    .cfg_mode       (cfg_mode),
    .start          (start),
    .abort          (abort),
    .m_axis_data    (bus),
    .busy           (busy),
    .done           (done),
    .sweep_count    (sweep_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] val;
    int          cnt;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        ce;
  logic [31:0] want[$];
  int          total = 0, bad = 0;
  int          hs_n, done_n, last_cnt, gap_exp;
  longint      cyc = 0, last_hs = -1;
  bit          chk_on = 0, gap_on = 0, prev_stall = 0;
  logic [31:0] prev_data;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // expected accepted values: one list per leg, clamped at the target
  task automatic build(input logic [31:0] s, p, d,
                       input logic [1:0] md, input int n);
    longint a, b, v, dd;
    longint lv[$];
    int c;
    bit outb, incl;
    a = s; b = p; dd = d; c = 0; outb = 1; incl = 1;
    exp_q.delete();
    for (int it = 0; it < 1000; it++) begin
      lv.delete();
      v = a;
      lv.push_back(v);
      if (dd != 0)
        while (v != b) begin
          if (b > a) v = (v + dd > b) ? b : v + dd;
          else       v = (v - dd < b) ? b : v - dd;
          lv.push_back(v);
        end
      for (int i = incl ? 0 : 1; i < lv.size(); i++) begin
        ent_t e;
        e.val = 32'(lv[i]);
        if (i == lv.size() - 1 &&
            (md == 1 || (md == 2 && !outb))) c++;
        e.cnt = c;
        exp_q.push_back(e);
      end
      if (md == 0 || md == 3 || exp_q.size() >= n) break;
      if (md == 2) begin
        v = a; a = b; b = v; outb = !outb; incl = 0;
      end
    end
  endtask

  task automatic pin(input string nm);
    for (int i = 0; i < want.size(); i++)
      chk(nm, (i < exp_q.size()) ? exp_q[i].val : 'x, want[i]);
  endtask

  always @(posedge aclk) cyc++;

  // per-cycle output checker
  always @(negedge aclk) begin
    if (!arst_n) begin
      prev_stall = 0;
    end else begin
      if (chk_on) begin
        if (prev_stall) begin
          chk("hold_valid", bus.tvalid, 1);
          chk("hold_data", bus.tdata, prev_data);
        end
        if (bus.tvalid && bus.tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", bus.tdata, 'x);
          end else begin
            ce = exp_q.pop_front();
            chk("tdata", bus.tdata, ce.val);
            last_cnt = ce.cnt;
            hs_n++;
            if (gap_on && last_hs >= 0)
              chk("gap", cyc - last_hs, gap_exp);
            last_hs = cyc;
          end
        end
        if (done) done_n++;
      end
      prev_stall = bus.tvalid && !bus.tready;
      prev_data  = bus.tdata;
    end
  end

  task automatic run(input logic [31:0] s, p, d,
                     input logic [15:0] dw,
                     input logic [1:0] md,
                     input int nstop, input int rdy);
    int first_v;
    bit rep, ab_sent, ok;
    rep = (md == 1 || md == 2);
    build(s, p, d, md, rep ? nstop + 8 : 0);
    hs_n = 0; done_n = 0; last_cnt = 0; last_hs = -1;
    gap_on = (rdy == 100); gap_exp = dw + 1; chk_on = 1;
    cfg_start_step = s; cfg_stop_step = p;
    cfg_delta = d; cfg_dwell = dw; cfg_mode = md;
    bus.tready = (rdy == 100);
    start = 1; first_v = 0; ab_sent = 0; ok = 0;
    for (int i = 1; i <= 5000; i++) begin
      @(posedge aclk); #1;
      start = 0; abort = 0;
      cfg_start_step = $urandom; cfg_stop_step = $urandom;
      cfg_delta = $urandom; cfg_dwell = 16'($urandom);
      cfg_mode = 2'($urandom);
      bus.tready = ($urandom_range(99) < rdy);
      if (first_v == 0 && bus.tvalid) first_v = i;
      if (!busy) begin ok = 1; break; end
      if (rep && !ab_sent && hs_n >= nstop) begin
        abort = 1; ab_sent = 1;
      end
    end
    chk("timeout", ok, 1);
    chk("latency", first_v, 2);
    if (rep) begin
      chk("rep_count", sweep_count, last_cnt);
      chk("rep_nodone", done_n, 0);
    end else begin
      chk("left_over", exp_q.size(), 0);
      chk("done_once", done_n, 1);
      chk("count_one", sweep_count, 1);
    end
    chk_on = 0; bus.tready = 0; exp_q.delete();
  endtask

  initial begin
    logic [31:0] s, p, d;
    logic [1:0]  md;
    bit          got_v;
    start = 0; abort = 0; bus.tready = 0;
    cfg_start_step = 0; cfg_stop_step = 0;
    cfg_delta = 0; cfg_dwell = 0; cfg_mode = 0;
    repeat (3) @(negedge aclk);
    chk("rst_tvalid", bus.tvalid, 0);
    chk("rst_tdata", bus.tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sweep_count, 0);
    arst_n = 1;
    @(posedge aclk); #1;

    build(32'h100, 32'h400, 32'h100, 0, 0);
    want = '{32'h100, 32'h200, 32'h300, 32'h400};
    pin("pin_up");
    run(32'h100, 32'h400, 32'h100, 2, 0, 0, 100);

    build(32'h500, 32'h100, 32'h180, 0, 0);
    want = '{32'h500, 32'h380, 32'h200, 32'h100};
    pin("pin_down");
    run(32'h500, 32'h100, 32'h180, 0, 0, 0, 100);

    build(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 0, 0);
    want = '{32'hFFFF_FF00, 32'hFFFF_FFFF};
    pin("pin_ovf");
    chk("pin_ovf_len", exp_q.size(), 2);
    run(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 1, 0, 0, 100);

    build(32'h0, 32'h300, 32'h100, 2, 8);
    want = '{32'h0, 32'h100, 32'h200, 32'h300,
             32'h200, 32'h100, 32'h0, 32'h100};
    pin("pin_tri");
    chk("pin_tri_c5", exp_q[5].cnt, 0);
    chk("pin_tri_c6", exp_q[6].cnt, 1);
    run(32'h0, 32'h300, 32'h100, 0, 2, 14, 100);

    build(32'h10, 32'h30, 32'h10, 1, 6);
    want = '{32'h10, 32'h20, 32'h30,
             32'h10, 32'h20, 32'h30};
    pin("pin_saw");
    chk("pin_saw_c2", exp_q[2].cnt, 1);
    run(32'h10, 32'h30, 32'h10, 1, 1, 9, 70);

    run(32'h42, 32'h42, 32'h5, 1, 0, 0, 100);
    run(32'h80, 32'h200, 32'h0, 0, 3, 0, 100);

    // backpressure with abort while stalled
    build(32'h10, 32'h40, 32'h10, 0, 0);
    hs_n = 0; done_n = 0; gap_on = 0; last_hs = -1;
    chk_on = 1;
    cfg_start_step = 32'h10; cfg_stop_step = 32'h40;
    cfg_delta = 32'h10; cfg_dwell = 0; cfg_mode = 0;
    bus.tready = 0; start = 1;
    @(posedge aclk); #1;
    start = 0;
    got_v = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tvalid) begin got_v = 1; break; end
      @(posedge aclk); #1;
    end
    chk("bp_valid", got_v, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge aclk); #1;
      abort = (i == 1);
      chk("bp_hold_v", bus.tvalid, 1);
      chk("bp_hold_d", bus.tdata, 32'h10);
    end
    abort = 0;
    chk("bp_busy", busy, 1);
    bus.tready = 1;
    @(posedge aclk); #1;
    bus.tready = 0;
    chk("bp_idle", busy, 0);
    chk("bp_tvalid", bus.tvalid, 0);
    chk("bp_beats", hs_n, 1);
    chk("bp_nodone", done_n, 0);
    chk_on = 0; exp_q.delete();

    // start and abort together in IDLE
    @(posedge aclk); #1;
    start = 1; abort = 1;
    @(posedge aclk); #1;
    start = 0; abort = 0;
    chk("sa_busy1", busy, 0);
    @(posedge aclk); #1;
    chk("sa_busy2", busy, 0);
    chk("sa_tvalid", bus.tvalid, 0);

    // asynchronous reset mid-sweep
    cfg_start_step = 32'h77; cfg_stop_step = 32'h99;
    cfg_delta = 32'h11; cfg_dwell = 0; cfg_mode = 1;
    bus.tready = 1; start = 1;
    @(posedge aclk); #1;
    start = 0;
    repeat (12) @(posedge aclk);
    #1;
    chk("mid_tvalid", bus.tvalid, 1);
    chk("mid_count_nz", sweep_count != 0, 1);
    #2 arst_n = 0;
    #1;
    chk("ar_tvalid", bus.tvalid, 0);
    chk("ar_tdata", bus.tdata, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_count", sweep_count, 0);
    bus.tready = 0;
    @(negedge aclk);
    arst_n = 1;
    @(posedge aclk); #1;

    for (int k = 0; k < 24; k++) begin
      md = 2'($urandom_range(3));
      s = $urandom_range(32'h7FF);
      p = $urandom_range(32'h7FF);
      if ($urandom_range(3) == 0) begin
        s |= 32'hFFFF_F000;
        p |= 32'hFFFF_F000;
      end
      d = $urandom_range(32'h200, 32'h20);
      if (md == 2 && s == p) p = s + 1;
      run(s, p, d, 16'($urandom_range(3)), md,
          $urandom_range(25, 6),
          $urandom_range(1) ? 100 : 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
